// File: rtl/nrdiv_seq_pipe_pkg.sv
// Shared definitions for the nrdiv_seq_pipe divider: FSM state codes and counter sizing.
package nrdiv_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] INIT = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    // The iteration counter must be able to hold the value W itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nrdiv_seq_pipe_if.sv
// Operand/result bus of the nrdiv_seq_pipe divider; master = producer/consumer, slave = divider.
interface nrdiv_seq_pipe_if #(parameter int W = 16);

    // Handshake: a beat transfers on a rising edge where valid && ready; the source holds
    // valid and its payload stable until that edge, and ready never depends on valid.
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/nrdiv_seq_pipe_step.sv
// One combinational non-restoring division step: shift in the next dividend bit, add or subtract M.
module nrdiv_step #(
    parameter int W = 16
) (
    input  logic [W:0]   r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] m_i,
    output logic [W:0]   r_o,
    output logic [W-1:0] q_o
);

    logic [W:0] r_sh;
    logic [W:0] m_ext;

    // The add/subtract decision uses the sign of R before the shift, which is the only
    // place the full sign survives; the shifted value may wrap modulo 2^(W+1).
    always_comb begin
        m_ext = {1'b0, m_i};
        r_sh  = {r_i[W-1:0], q_i[W-1]};
        r_o   = r_i[W] ? (r_sh + m_ext) : (r_sh - m_ext);
    end

    assign q_o = {q_i[W-2:0], ~r_o[W]};

endmodule

// File: rtl/nrdiv_seq_pipe.sv
// Sequential non-restoring divider, UNROLL steps per clock, one division in flight.
// Optional signed mode is compiled in with NRDIV_SIGNED_EN.
module nrdiv_seq_pipe
    import nrdiv_pkg::*;
#(
    parameter int W      = 16,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    nrdiv_seq_pipe_if.slave bus,
    output logic [2:0]      state_dbg
);

    localparam int CW = cnt_w(W);

    logic [2:0]    state_q, state_d;
    logic [W:0]    r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    r_fix;
    logic [W-1:0]  a_abs, b_abs, quot_fix, rem_fix;
    logic [W:0]    r_next;
    logic [W-1:0]  q_next;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [W:0]   r_in, r_out;
        logic [W-1:0] q_in, q_out;
        if (i == 0) begin : g_first
            assign r_in = r_q;
            assign q_in = q_q;
        end else begin : g_next
            assign r_in = g_step[i-1].r_out;
            assign q_in = g_step[i-1].q_out;
        end
        nrdiv_step #(.W(W)) u_step (
            .r_i (r_in),
            .q_i (q_in),
            .m_i (m_q),
            .r_o (r_out),
            .q_o (q_out)
        );
    end

    assign r_next = g_step[UNROLL-1].r_out;
    assign q_next = g_step[UNROLL-1].q_out;
    assign r_fix  = r_q[W] ? (r_q + {1'b0, m_q}) : r_q;

`ifdef NRDIV_SIGNED_EN
    logic sgn_q, sgn_d;
    logic a_neg, b_neg;

    always_comb begin
        sgn_d = sgn_q;
        if (state_q == IDLE && bus.in_valid) sgn_d = bus.in_signed;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sgn_q <= 1'b0;
        else          sgn_q <= sgn_d;
    end

    assign a_neg    = sgn_q & a_q[W-1];
    assign b_neg    = sgn_q & b_q[W-1];
    assign a_abs    = a_neg ? -a_q : a_q;
    assign b_abs    = b_neg ? -b_q : b_q;
    assign quot_fix = (a_neg ^ b_neg) ? -q_q : q_q;
    assign rem_fix  = a_neg ? -r_fix[W-1:0] : r_fix[W-1:0];
`else
    logic unused_signed;
    assign unused_signed = bus.in_signed;
    assign a_abs    = a_q;
    assign b_abs    = b_q;
    assign quot_fix = q_q;
    assign rem_fix  = r_fix[W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
                    state_d = INIT;
                end
            end
            INIT: begin
                r_d     = '0;
                q_d     = a_abs;
                m_d     = b_abs;
                cnt_d   = '0;
                state_d = (b_q == '0) ? FIX : ITER;
            end
            ITER: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(UNROLL);
                if (cnt_d == CW'(W)) state_d = FIX;
            end
            FIX: begin
                // A zero divisor skips the iterations entirely and reports the raw dividend.
                if (b_q == '0) begin
                    quot_d = '1;
                    rem_d  = a_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                    dbz_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_nrdiv_seq_pipe.sv
// Bench for nrdiv_seq_pipe: UNROLL=1 and UNROLL=4 instances against an arithmetic division model.
module tb_nrdiv_seq_pipe;

    localparam int W = 16;
`ifdef NRDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [2:0] state1, state4;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2*W:0] exp_q[$];

    nrdiv_seq_pipe_if #(.W(W)) bus1 ();
    nrdiv_seq_pipe_if #(.W(W)) bus4 ();

    nrdiv_seq_pipe #(.W(W), .UNROLL(1)) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus1),
        .state_dbg (state1)
    );

    nrdiv_seq_pipe #(.W(W), .UNROLL(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus4),
        .state_dbg (state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; SV '/' and '%' truncate toward zero.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
        longint sa, sb, qq, rr;
        logic   use_s;
        use_s = sgn && SIGNED_EN;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        sa = longint'(a);
        sb = longint'(b);
        if (use_s && a[W-1]) sa = sa - (longint'(1) << W);
        if (use_s && b[W-1]) sb = sb - (longint'(1) << W);
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, W'(qq), W'(rr)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn);
        logic rdy;
        @(negedge clk);
        if (sel == 4) begin
            bus4.in_valid = 1'b1; bus4.dividend = a; bus4.divisor = b; bus4.in_signed = sgn;
            rdy = bus4.in_ready;
        end else begin
            bus1.in_valid = 1'b1; bus1.dividend = a; bus1.divisor = b; bus1.in_signed = sgn;
            rdy = bus1.in_ready;
        end
        check("accept_ready", 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        exp_q.push_back(model(a, b, sgn));
    endtask

    task automatic wait_result(input int sel, input int exp_lat, input string tag);
        int           lat;
        logic         ov;
        logic [2*W:0] e;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            ov = (sel == 4) ? bus4.out_valid : bus1.out_valid;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        e = exp_q.pop_front();
        if (sel == 4) begin
            check({tag, "_quot"}, 64'(bus4.quotient), 64'(e[2*W-1:W]));
            check({tag, "_rem"},  64'(bus4.remainder), 64'(e[W-1:0]));
            check({tag, "_dbz"},  64'(bus4.div_by_zero), 64'(e[2*W]));
        end else begin
            check({tag, "_quot"}, 64'(bus1.quotient), 64'(e[2*W-1:W]));
            check({tag, "_rem"},  64'(bus1.remainder), 64'(e[W-1:0]));
            check({tag, "_dbz"},  64'(bus1.div_by_zero), 64'(e[2*W]));
        end
    endtask

    task automatic consume(input int sel);
        @(negedge clk);
        bus1.out_ready = (sel == 1);
        bus4.out_ready = (sel == 4);
        @(posedge clk);
        #1;
        check("consume_idle", (sel == 4) ? 64'(bus4.in_ready) : 64'(bus1.in_ready), 64'd1);
        check("consume_clear", (sel == 4) ? 64'(bus4.out_valid) : 64'(bus1.out_valid), 64'd0);
        bus1.out_ready = 1'b0;
        bus4.out_ready = 1'b0;
    endtask

    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input string tag);
        int lat;
        lat = (b == '0) ? 2 : ((sel == 4) ? W / 4 + 2 : W + 2);
        launch(sel, a, b, sgn);
        wait_result(sel, lat, tag);
        consume(sel);
    endtask

    initial begin
        int           sel;
        logic [W-1:0] ra, rb;
        logic         rs;
        logic [2*W:0] drop;

        reset_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_signed = 1'b0; bus1.dividend = '0; bus1.divisor = '0;
        bus1.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_signed = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus4.out_ready = 1'b0;
        #25;
        check("reset_in_ready", 64'(bus1.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus1.out_valid), 64'd0);
        check("reset_quot", 64'(bus1.quotient), 64'd0);
        check("reset_rem", 64'(bus1.remainder), 64'd0);
        check("reset_dbz", 64'(bus1.div_by_zero), 64'd0);
        check("reset_state_pair", 64'(state4), 64'(state1));
        @(negedge clk);
        reset_n = 1'b1;

        run_op(1, 16'd100, 16'd7, 1'b0, "u1_100_7");
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, "u1_ffff_1");
        run_op(1, 16'h0005, 16'h0009, 1'b0, "u1_5_9");
        run_op(4, 16'd100, 16'd7, 1'b0, "u4_100_7");
        run_op(4, 16'hFFFF, 16'h0001, 1'b0, "u4_ffff_1");
        run_op(4, 16'h0005, 16'h0009, 1'b0, "u4_5_9");
        run_op(1, 16'd1234, 16'd0, 1'b0, "u1_div0");
        run_op(4, 16'd1234, 16'd0, 1'b1, "u4_div0");
        run_op(1, 16'hFFF9, 16'h0002, 1'b1, "s_m7_2");
        run_op(1, 16'h0007, 16'hFFFE, 1'b1, "s_7_m2");
        run_op(1, 16'hFFF9, 16'h0002, 1'b0, "us_m7_2");
        run_op(1, 16'h0007, 16'hFFFE, 1'b0, "us_7_m2");
        run_op(4, 16'h8000, 16'hFFFF, 1'b1, "s_min_m1");

        // out_ready held high before the result exists must not shorten the operation.
        bus1.out_ready = 1'b1;
        launch(1, 16'd60000, 16'd13, 1'b0);
        wait_result(1, W + 2, "early_ready");
        @(posedge clk);
        #1;
        check("early_ready_clear", 64'(bus1.out_valid), 64'd0);
        bus1.out_ready = 1'b0;

        // Back-pressure with a competing request pending.
        launch(1, 16'd100, 16'd7, 1'b0);
        wait_result(1, W + 2, "bp_first");
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.dividend = 16'd500; bus1.divisor = 16'd3;
        bus1.in_signed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 64'(bus1.out_valid), 64'd1);
            check("bp_quot_stable", 64'(bus1.quotient), 64'd14);
            check("bp_rem_stable", 64'(bus1.remainder), 64'd2);
            check("bp_busy", 64'(bus1.in_ready), 64'd0);
        end
        @(negedge clk);
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_idle", 64'(bus1.in_ready), 64'd1);
        check("bp_release_clear", 64'(bus1.out_valid), 64'd0);
        bus1.out_ready = 1'b0;
        exp_q.push_back(model(16'd500, 16'd3, 1'b0));
        @(posedge clk);
        #1;
        check("bp_back_to_back", 64'(bus1.in_ready), 64'd0);
        bus1.in_valid = 1'b0;
        wait_result(1, W + 2, "bp_second");
        consume(1);

        // Reset in the middle of the iterations.
        launch(1, 16'd100, 16'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 64'(bus1.in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(bus1.out_valid), 64'd0);
        check("rst_mid_quot", 64'(bus1.quotient), 64'd0);
        check("rst_mid_rem", 64'(bus1.remainder), 64'd0);
        check("rst_mid_dbz", 64'(bus1.div_by_zero), 64'd0);
        drop = exp_q.pop_front();
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1, 16'd100, 16'd7, 1'b0, "after_rst");

        for (int n = 0; n < 24; n++) begin
            sel = ($urandom_range(0, 1) == 1) ? 4 : 1;
            ra  = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            rs = 1'($urandom_range(0, 1));
            run_op(sel, ra, rb, rs, "rand");
        end

        if (drop[2*W] === 1'bx) $display("note: discarded entry undefined");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
